spi_reg_slave_rw: RTL
=====================

// Module: spi_reg_slave_rw
// PURPOSE
//  SPI (mode 0) target with read-back that sits between the ui_in SPI pins and pwm_peripheral.
//  Decodes 16-bit frames into a small register bank that drives the output-enable, PWM-enable and duty-cycle inputs of pwm_peripheral.
//  Adds CIPO readback and a saturating frame-error counter for bring-up debug.
//  All logic runs in the system clk domain; SPI pins are oversampled.
// PARAMETERS
//  SYNC_STAGES  2   flops in each pin synchronizer (>=2)
//  NUM_RW_REGS  5   writable registers at addresses 0..NUM_RW_REGS-1
//  ADDR_W       7   frame address field width (frame = 1 + ADDR_W + 8 bits)
// PORTS
//  clk              in   1  system clock; single clock domain
//  rst_n            in   1  synchronous active-low reset
//  sclk             in   1  SPI clock, asynchronous to clk
//  copi             in   1  SPI controller-out data, asynchronous
//  ncs              in   1  SPI chip select, active low, asynchronous
//  cipo             out  1  SPI target-out data
//  cipo_oe          out  1  1 while synchronized ncs is low
//  en_reg_out_7_0   out  8  reg 0x00
//  en_reg_out_15_8  out  8  reg 0x01
//  en_reg_pwm_7_0   out  8  reg 0x02
//  en_reg_pwm_15_8  out  8  reg 0x03
//  pwm_duty_cycle   out  8  reg 0x04
//  reg_wr_stb       out  1  1-cycle pulse on every committed register write
//  reg_wr_addr      out  7  address of the last committed write
// BEHAVIOUR
//  Reset: every output and register is 0, including cipo, cipo_oe, reg_wr_stb, reg_wr_addr and err_cnt.
//  Sync: each pin goes through SYNC_STAGES flops plus one history flop for edge detect.
//   SCLK high and low phases must each be >= SYNC_STAGES+2 clk cycles.
//  Frame format: MSB first; bit15 = R/W (1 = write), bits14:8 = addr, bits7:0 = data.
//  Sampling: copi is sampled on the synced sclk rising edge; cipo shifts on the synced sclk falling edge.
//  Bit counter: 5 bits, cleared on synced ncs falling edge. It saturates at 17 and never wraps.
//  FSM states:
//   IDLE -> RX on ncs fall.
//   RX -> COMMIT on ncs rise.
//   COMMIT -> IDLE after 1 cycle.
//   Any state -> IDLE on reset.
//  COMMIT (one clk cycle):
//   - Write frame with count == 16 and addr < NUM_RW_REGS: update the register; reg_wr_stb = 1; reg_wr_addr = addr.
//   - Write frame with count == 16 and addr == 0x05: clear err_cnt; reg_wr_stb = 1.
//   - Read frame with count == 16: no register change, no strobe.
//   - Any other case (count != 16, or write addr > 0x05): no register change; err_cnt += 1, saturating at 0xFF.
//  Write latency: register value changes SYNC_STAGES+2 clk cycles after raw ncs rises.
//  Readback:
//   - On the sclk rising edge that completes bit 8 with R/W = 0, load the shift-out register with the addressed value:
//     regs 0..4, err_cnt at 0x05, 0x00 for any other address.
//   - cipo shows data bit7 from the next sclk fall, then the remaining bits MSB first, one per fall.
//   - cipo = 0 before that point and whenever ncs is high.
//  Reads have no side effects, including out-of-range reads.
//  Overlength: bits after 16 are ignored and cipo = 0. The frame is an error at COMMIT.
//  Glitch: ncs high for less than SYNC_STAGES clk cycles may be missed. Such a frame is treated as one long frame and counted as an error.
//  Reset mid-frame: the frame is discarded and registers go to 0.
//   If rst_n is released while ncs is low, the block stays IDLE until it sees an ncs rise followed by a fall.
//  Simultaneous ncs rise and sclk edge in the same synced cycle: the ncs rise wins and that sclk edge is ignored.
// TESTING
//  T1 reset: hold rst_n = 0 for 5 clk -> all outputs 0. Read 0x05 -> cipo byte 0x00.
//  T2 write: frame 0x80F0 -> en_reg_out_7_0 = 0xF0.
//   reg_wr_stb pulses exactly once; reg_wr_addr = 0x00; other regs unchanged.
//  T3 duty + readback: write 0x8480, then read frame 0x0400 -> pwm_duty_cycle = 0x80.
//   Captured cipo bits 8..15 = 0x80.
//  T4 malformed:
//   - 15-bit write to 0x01 -> reg unchanged, no strobe.
//   - 17-bit write -> discarded.
//   - write to 0x10 -> discarded.
//   - read 0x05 -> 0x03.
//   - write 0x8500, then read 0x05 -> 0x00.
//  T5 saturation: 300 short frames -> err_cnt reads 0xFF. The counter does not wrap.
//  T6 reset mid-frame: assert rst_n = 0 after 10 bits of 0x83AA with ncs held low.
//   -> en_reg_pwm_15_8 stays 0x00.
//   The next full frame 0x8355 after an ncs rise/fall -> 0x55.

Source files
------------

// File: rtl/spi_reg_slave_rw.sv
// spi_reg_slave_rw
//   SPI mode-0 target with readback, sitting between the SPI pins and
//   pwm_peripheral. 16-bit frames {rw, addr[6:0], data[7:0]} are decoded
//   into a small register bank. A saturating frame-error counter sits at
//   address 0x05 (read it to inspect, write it to clear). All logic is in
//   the clk domain; the SPI pins are oversampled.
// Ports
//   clk, rst_n         system clock, synchronous active-low reset
//   sclk, copi, ncs    raw SPI pins (asynchronous to clk)
//   cipo, cipo_oe      SPI target-out data and its output enable
//   en_reg_*, pwm_duty_cycle   register bank outputs (addresses 0..4)
//   reg_wr_stb         1-cycle pulse per committed write
//   reg_wr_addr        address of the last committed write

// Pin synchronizer: STAGES flops, no history (the top keeps that).
module spi_pin_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic q
);
    logic [STAGES-1:0] chain;

    always_ff @(posedge clk) begin
        if (!rst_n) chain <= '0;
        else        chain <= {chain[STAGES-2:0], din};
    end

    assign q = chain[STAGES-1];
endmodule

module spi_reg_slave_rw #(
    parameter int SYNC_STAGES = 2,
    parameter int NUM_RW_REGS = 5,
    parameter int ADDR_W      = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sclk,
    input  logic              copi,
    input  logic              ncs,
    output logic              cipo,
    output logic              cipo_oe,
    output logic [7:0]        en_reg_out_7_0,
    output logic [7:0]        en_reg_out_15_8,
    output logic [7:0]        en_reg_pwm_7_0,
    output logic [7:0]        en_reg_pwm_15_8,
    output logic [7:0]        pwm_duty_cycle,
    output logic              reg_wr_stb,
    output logic [ADDR_W-1:0] reg_wr_addr
);
    localparam int                FRAME_BITS = 1 + ADDR_W + 8;
    localparam logic [4:0]        CNT_FULL   = 5'(FRAME_BITS);
    localparam logic [4:0]        CNT_SAT    = 5'(FRAME_BITS + 1);
    localparam logic [4:0]        CNT_ADDR   = 5'(ADDR_W);
    localparam logic [ADDR_W-1:0] ERR_ADDR   = ADDR_W'(5);

    typedef enum logic [1:0] {IDLE, RX, COMMIT} state_t;

    // pin index: 0 = sclk, 1 = copi, 2 = ncs
    logic [2:0] pin_raw, pin_q, pin_d;
    assign pin_raw = {ncs, copi, sclk};

    for (genvar p = 0; p < 3; p++) begin : g_sync
        spi_pin_sync #(.STAGES(SYNC_STAGES)) u_sync (
            .clk  (clk),
            .rst_n(rst_n),
            .din  (pin_raw[p]),
            .q    (pin_q[p])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) pin_d <= '0;
        else        pin_d <= pin_q;
    end

    logic sclk_rise, sclk_fall, ncs_rise, ncs_fall, ncs_s, copi_s;
    assign sclk_rise = pin_q[0] & ~pin_d[0];
    assign sclk_fall = ~pin_q[0] & pin_d[0];
    assign ncs_s     = pin_q[2];
    assign ncs_rise  = pin_q[2] & ~pin_d[2];
    assign ncs_fall  = ~pin_q[2] & pin_d[2];
    // copi from its history flop: the value held just before the sclk rise
    // reached the sync output, like the setup window of a real target flop.
    assign copi_s    = pin_d[1];

    state_t                        state;
    logic [FRAME_BITS-1:0]         rx_sh;
    logic [4:0]                    bit_cnt;
    logic [7:0]                    tx_sh;
    logic [3:0]                    tx_left;
    logic [NUM_RW_REGS-1:0][7:0]   regs;
    logic [7:0]                    err_cnt;
    logic                          ncs_seen;

    // Readback source, addressed by the 7 bits completing with this rise.
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;
    always_comb begin
        rd_addr = {rx_sh[ADDR_W-2:0], copi_s};
        rd_data = 8'h00;
        if (rd_addr == ERR_ADDR) rd_data = err_cnt;
        for (int i = 0; i < NUM_RW_REGS; i++)
            if (rd_addr == ADDR_W'(i)) rd_data = regs[i];
    end

    logic              cm_rw, cm_full;
    logic [ADDR_W-1:0] cm_addr;
    logic [7:0]        cm_data;
    assign cm_rw   = rx_sh[FRAME_BITS-1];
    assign cm_addr = rx_sh[FRAME_BITS-2 -: ADDR_W];
    assign cm_data = rx_sh[7:0];
    assign cm_full = (bit_cnt == CNT_FULL);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            rx_sh       <= '0;
            bit_cnt     <= '0;
            tx_sh       <= '0;
            tx_left     <= '0;
            regs        <= '0;
            err_cnt     <= '0;
            ncs_seen    <= 1'b0;
            cipo        <= 1'b0;
            cipo_oe     <= 1'b0;
            reg_wr_stb  <= 1'b0;
            reg_wr_addr <= '0;
        end else begin
            reg_wr_stb <= 1'b0;
            // ncs must be seen high after reset before a frame can start or
            // the output enable can assert (reset released mid-frame).
            if (ncs_s) ncs_seen <= 1'b1;
            cipo_oe <= ncs_seen & ~ncs_s;

            case (state)
                IDLE: begin
                    cipo <= 1'b0;
                    if (ncs_fall) begin
                        state   <= RX;
                        bit_cnt <= '0;
                        tx_left <= '0;
                    end
                end
                RX: begin
                    if (ncs_rise) begin
                        // ncs rise wins over a coincident sclk edge
                        state <= COMMIT;
                        cipo  <= 1'b0;
                    end else begin
                        if (sclk_rise) begin
                            if (bit_cnt < CNT_FULL)
                                rx_sh <= {rx_sh[FRAME_BITS-2:0], copi_s};
                            if (bit_cnt != CNT_SAT)
                                bit_cnt <= bit_cnt + 5'd1;
                            // rx_sh[ADDR_W-1] is the R/W bit at this point
                            if (bit_cnt == CNT_ADDR && !rx_sh[ADDR_W-1]) begin
                                tx_sh   <= rd_data;
                                tx_left <= 4'd8;
                            end
                        end
                        if (sclk_fall) begin
                            if (tx_left != 4'd0) begin
                                cipo    <= tx_sh[7];
                                tx_sh   <= {tx_sh[6:0], 1'b0};
                                tx_left <= tx_left - 4'd1;
                            end else begin
                                cipo <= 1'b0;
                            end
                        end
                    end
                end
                COMMIT: begin
                    state <= IDLE;
                    cipo  <= 1'b0;
                    if (cm_full && !cm_rw) begin
                        // reads are side-effect free
                    end else if (cm_full && cm_addr == ERR_ADDR) begin
                        err_cnt     <= 8'h00;
                        reg_wr_stb  <= 1'b1;
                        reg_wr_addr <= cm_addr;
                    end else if (cm_full && cm_addr < ERR_ADDR) begin
                        for (int i = 0; i < NUM_RW_REGS; i++)
                            if (cm_addr == ADDR_W'(i)) regs[i] <= cm_data;
                        reg_wr_stb  <= 1'b1;
                        reg_wr_addr <= cm_addr;
                    end else if (err_cnt != 8'hFF) begin
                        err_cnt <= err_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign en_reg_out_7_0  = regs[0];
    assign en_reg_out_15_8 = regs[1];
    assign en_reg_pwm_7_0  = regs[2];
    assign en_reg_pwm_15_8 = regs[3];
    assign pwm_duty_cycle  = regs[4];
endmodule
